// File: rtl/alu_exec_unit.sv
// alu_exec_unit: execute-stage controller wrapped around a 4-bit ALU.
//   Accepts one decoded instruction at a time (IDLE -> EXEC -> WB). It reads
//   the operands from a small register file, drives the ALU from latched
//   registers, captures the ALU result and flags, writes the result back, and
//   presents it downstream until that side accepts it.
//
// Optional feature macro: ALU_EXEC_CMP_EN
//   When defined, op 4'b1111 is CMP: the ALU runs a subtract (mode 4'b0010),
//   only the flags update, and out_data returns the unchanged reg[rd].
//   When undefined, op 4'b1111 is a plain default op and its result is written.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   in_valid/in_ready               instruction handshake
//   in_op, in_rd, in_rs             ALU mode, destination/A register, B register
//   in_imm, in_use_imm              immediate B operand and B-source select
//   alu_a, alu_b, alu_mode          ALU operand and mode drive (registered)
//   alu_carry_f, alu_borrow_f       flag register bits 0 and 1 going to the ALU
//   alu_c, alu_flags                ALU result and {lt, zero, borrow, carry}
//   out_valid/out_ready             result handshake
//   out_data, out_flags             written-back result and the flag register

module alu_exec_unit #(
  parameter int unsigned NREGS     = 4,
  parameter logic [3:0]  FLAGS_RST = 4'b0000,
  localparam int unsigned RW       = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [3:0]    in_op,
  input  logic [RW-1:0] in_rd,
  input  logic [RW-1:0] in_rs,
  input  logic [3:0]    in_imm,
  input  logic          in_use_imm,
  output logic [3:0]    alu_a,
  output logic [3:0]    alu_b,
  output logic [3:0]    alu_mode,
  output logic          alu_carry_f,
  output logic          alu_borrow_f,
  input  logic [3:0]    alu_c,
  input  logic [3:0]    alu_flags,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [3:0]    out_data,
  output logic [3:0]    out_flags
);

  localparam int unsigned DW = 4;

  localparam logic [3:0] OP_ADC = 4'b0001;
  localparam logic [3:0] OP_SBB = 4'b0011;
  localparam logic [3:0] OP_CMP = 4'b1111;
  localparam logic [3:0] MODE_SUB = 4'b0010;

  localparam int unsigned FL_CARRY  = 0;
  localparam int unsigned FL_BORROW = 1;
  localparam int unsigned FL_ZERO   = 2;
  localparam int unsigned FL_LT     = 3;

  // Reject register-file sizes the port widths cannot describe.
  if (NREGS < 2 || NREGS > 4 || (NREGS & (NREGS - 1)) != 0) begin : g_bad_nregs
    $error("alu_exec_unit: NREGS must be 2 or 4");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic          in_ready_q, in_ready_d;
  logic          out_valid_q, out_valid_d;
  logic          accept;
  logic          capture;

  logic [DW-1:0] a_q;
  logic [DW-1:0] b_q;
  logic [DW-1:0] mode_q;
  logic [DW-1:0] op_q;
  logic [RW-1:0] rd_q;
  logic [DW-1:0] flags_q, flags_d;
  logic [DW-1:0] out_data_q;
  logic [DW-1:0] regs [NREGS];

  logic          in_is_cmp;
  logic          is_cmp;

  // CMP decode for the incoming op (mode remap) and the latched op (no write).
`ifdef ALU_EXEC_CMP_EN
  assign in_is_cmp = (in_op == OP_CMP);
  assign is_cmp    = (op_q == OP_CMP);
`else
  assign in_is_cmp = 1'b0;
  assign is_cmp    = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Next state; handshake outputs are registered from the next state.
  always_comb begin
    state_d     = state_q;
    accept      = 1'b0;
    capture     = 1'b0;
    in_ready_d  = 1'b0;
    out_valid_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          accept  = 1'b1;
          state_d = EXEC;
        end
      end
      EXEC: begin
        capture = 1'b1;
        state_d = WB;
      end
      WB: begin
        if (out_valid_q && out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == WB);
  end

  // Flag merge: zero/lt always follow the ALU, carry/borrow only on their ops.
  always_comb begin
    flags_d           = flags_q;
    flags_d[FL_ZERO]  = alu_flags[FL_ZERO];
    flags_d[FL_LT]    = alu_flags[FL_LT];
    if (op_q == OP_ADC) begin
      flags_d[FL_CARRY] = alu_flags[FL_CARRY];
    end
    if (op_q == OP_SBB) begin
      flags_d[FL_BORROW] = alu_flags[FL_BORROW];
    end
  end

  // Operand latch at accept; the ALU is driven only from these registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      mode_q <= '0;
      op_q   <= '0;
      rd_q   <= '0;
    end else if (accept) begin
      a_q    <= regs[in_rd];
      b_q    <= in_use_imm ? in_imm : regs[in_rs];
      mode_q <= in_is_cmp ? MODE_SUB : in_op;
      op_q   <= in_op;
      rd_q   <= in_rd;
    end
  end

  // Result capture at the end of EXEC; held through WB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q    <= FLAGS_RST;
      out_data_q <= '0;
    end else if (capture) begin
      flags_q    <= flags_d;
      out_data_q <= is_cmp ? a_q : alu_c;
    end
  end

  // Register file; reads happen only in IDLE so they never race this write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs <= '{default: '0};
    end else if (capture && !is_cmp) begin
      regs[rd_q] <= alu_c;
    end
  end

  assign in_ready     = in_ready_q;
  assign out_valid    = out_valid_q;
  assign out_data     = out_data_q;
  assign out_flags    = flags_q;
  assign alu_a        = a_q;
  assign alu_b        = b_q;
  assign alu_mode     = mode_q;
  assign alu_carry_f  = flags_q[FL_CARRY];
  assign alu_borrow_f = flags_q[FL_BORROW];

endmodule
